// File: rtl/inst_class_history_if.sv
// rtl/inst_class_history_if.sv - issue-stage class history bus: handshake inputs and window outputs
interface inst_class_history_if #(
  parameter int NR_CLASSES = 4,
  parameter int HIST_LEN   = 14,
  parameter int CNT_W      = 32
);
  localparam int CW = $clog2(HIST_LEN + 1);

  logic                           flush_i;
  logic                           instr_valid_i;
  logic                           instr_ack_i;
  logic [NR_CLASSES-1:0]          class_i;
  logic [NR_CLASSES*HIST_LEN-1:0] hist_o;
  logic [NR_CLASSES*CW-1:0]       cnt_o;
  logic                           full_o;
  logic [NR_CLASSES*CNT_W-1:0]    perf_cnt_o;

  modport master (
    output flush_i, instr_valid_i, instr_ack_i, class_i,
    input  hist_o, cnt_o, full_o, perf_cnt_o
  );

  modport slave (
    input  flush_i, instr_valid_i, instr_ack_i, class_i,
    output hist_o, cnt_o, full_o, perf_cnt_o
  );
endinterface

// File: rtl/inst_class_history.sv
// rtl/inst_class_history.sv - sliding window of issued instruction classes with per-class counts
// Optional lifetime per-class counters: define INST_CLASS_HIST_PERF_CNT_EN.
module inst_class_history #(
  parameter int NR_CLASSES = 4,
  parameter int HIST_LEN   = 14,
  parameter int OUT_DELAY  = 1,
  parameter bit FREE_RUN   = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  inst_class_history_if.slave bus
);
  localparam int            CW       = $clog2(HIST_LEN + 1);
  localparam int            OW       = NR_CLASSES * (HIST_LEN + CW) + 1;
  localparam logic [CW-1:0] FILL_MAX = CW'(HIST_LEN);

  typedef logic [NR_CLASSES-1:0][HIST_LEN-1:0] hist_t;
  typedef logic [NR_CLASSES-1:0][CW-1:0]       cnt_t;

  logic                  hs;
  logic                  shift;
  logic [NR_CLASSES-1:0] in_bits;
  hist_t                 hist_q, hist_d;
  cnt_t                  cnt_q, cnt_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic [OW-1:0]         win_now;
  logic [OW-1:0]         win_out;

  assign hs      = bus.instr_valid_i & bus.instr_ack_i;
  assign in_bits = hs ? bus.class_i : '0;
  // Legacy free-running mode ages the window on idle cycles by shifting in zeros.
  assign shift   = FREE_RUN ? 1'b1 : hs;

  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    fill_d = fill_q;
    if (bus.flush_i) begin
      hist_d = '0;
      cnt_d  = '0;
      fill_d = '0;
    end else begin
      if (shift) begin
        for (int c = 0; c < NR_CLASSES; c++) begin
          hist_d[c] = {in_bits[c], hist_q[c][HIST_LEN-1:1]};
          cnt_d[c]  = cnt_q[c] + CW'(in_bits[c]) - CW'(hist_q[c][0]);
        end
      end
      if (hs && (fill_q != FILL_MAX)) begin
        fill_d = fill_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hist_q <= '0;
      cnt_q  <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
    end
  end

  assign win_now = {(fill_q == FILL_MAX), cnt_q, hist_q};

  generate
    if (OUT_DELAY == 0) begin : g_direct
      assign win_out = win_now;
    end else begin : g_pipe
      logic [OUT_DELAY-1:0][OW-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d = pipe_q;
        if (bus.flush_i) begin
          pipe_d = '0;
        end else begin
          pipe_d[0] = win_now;
          for (int i = 1; i < OUT_DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign win_out = pipe_q[OUT_DELAY-1];
    end
  endgenerate

  assign bus.hist_o = win_out[NR_CLASSES*HIST_LEN-1:0];
  assign bus.cnt_o  = win_out[OW-2 -: NR_CLASSES*CW];
  assign bus.full_o = win_out[OW-1];

`ifdef INST_CLASS_HIST_PERF_CNT_EN
  logic                             rec;
  logic [NR_CLASSES-1:0][CNT_W-1:0] perf_q, perf_d;

  // A flushed handshake is never recorded, so it does not count either; flush never clears these.
  assign rec = hs & ~bus.flush_i;

  always_comb begin
    perf_d = perf_q;
    for (int c = 0; c < NR_CLASSES; c++) begin
      if (rec && bus.class_i[c] && (perf_q[c] != {CNT_W{1'b1}})) begin
        perf_d[c] = perf_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign bus.perf_cnt_o = perf_q;
`else
  assign bus.perf_cnt_o = {(NR_CLASSES*CNT_W){1'b0}};
`endif

  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (hs) begin
        assert ($onehot0(bus.class_i));
      end
      for (int c = 0; c < NR_CLASSES; c++) begin
        assert (int'(cnt_q[c]) == $countones(hist_q[c]));
      end
    end
  end
endmodule

// File: tb/tb_inst_class_history.sv
// tb/tb_inst_class_history.sv - scoreboard bench: delayed/handshake instance A, free-running instance B
module tb_inst_class_history;
  localparam int NC      = 4;
  localparam int HL      = 14;
  localparam int CW      = 4;
  localparam int CNT_W_A = 32;
  localparam int CNT_W_B = 4;
  localparam int K_HIST  = 0;
  localparam int K_CNT   = 1;
  localparam int K_FULL  = 2;
  localparam int K_PERF  = 3;
`ifdef INST_CLASS_HIST_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_class_history_if #(.NR_CLASSES(NC), .HIST_LEN(HL), .CNT_W(CNT_W_A)) bus_a ();
  inst_class_history_if #(.NR_CLASSES(NC), .HIST_LEN(HL), .CNT_W(CNT_W_B)) bus_b ();

  inst_class_history #(.NR_CLASSES(NC), .HIST_LEN(HL), .OUT_DELAY(1), .FREE_RUN(1'b0),
                       .CNT_W(CNT_W_A)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a.slave));
  inst_class_history #(.NR_CLASSES(NC), .HIST_LEN(HL), .OUT_DELAY(0), .FREE_RUN(1'b1),
                       .CNT_W(CNT_W_B)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b.slave));

  typedef struct {
    string       name;
    int          due;
    int          dut;
    int          kind;
    int          idx;
    logic [63:0] exp;
  } chk_t;

  chk_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(int dut, int kind, int idx);
    logic [63:0] v;
    v = '0;
    if (dut == 0) begin
      case (kind)
        K_HIST:  v = 64'(bus_a.hist_o[idx*HL +: HL]);
        K_CNT:   v = 64'(bus_a.cnt_o[idx*CW +: CW]);
        K_FULL:  v = 64'(bus_a.full_o);
        default: v = 64'(bus_a.perf_cnt_o[idx*CNT_W_A +: CNT_W_A]);
      endcase
    end else begin
      case (kind)
        K_HIST:  v = 64'(bus_b.hist_o[idx*HL +: HL]);
        K_CNT:   v = 64'(bus_b.cnt_o[idx*CW +: CW]);
        K_FULL:  v = 64'(bus_b.full_o);
        default: v = 64'(bus_b.perf_cnt_o[idx*CNT_W_B +: CNT_W_B]);
      endcase
    end
    return v;
  endfunction

  // Monitor: compares every expectation that falls due at this cycle's negedge.
  always @(negedge clk) begin
    logic [63:0] a;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        a = actual(sb[i].dut, sb[i].kind, sb[i].idx);
        checks++;
        if (a !== sb[i].exp) begin
          failures++;
          $display("FAIL %s dut=%0d kind=%0d idx=%0d: got 0x%0h expected 0x%0h",
                   sb[i].name, sb[i].dut, sb[i].kind, sb[i].idx, a, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  function automatic logic [63:0] pf(int v);
    return PERF ? 64'(v) : 64'd0;
  endfunction

  task automatic exp_v(input string name, input int dut, input int dly, input int kind,
                       input int idx, input logic [63:0] val);
    chk_t e;
    e.name = name;
    e.due  = cyc + dly;
    e.dut  = dut;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = val;
    sb.push_back(e);
  endtask

  task automatic exp_zero(input string name, input int dut, input int dly);
    for (int c = 0; c < NC; c++) begin
      exp_v(name, dut, dly, K_HIST, c, 64'd0);
      exp_v(name, dut, dly, K_CNT, c, 64'd0);
    end
    exp_v(name, dut, dly, K_FULL, 0, 64'd0);
  endtask

  task automatic idle_all();
    bus_a.instr_valid_i = 1'b0; bus_a.instr_ack_i = 1'b0; bus_a.class_i = '0; bus_a.flush_i = 1'b0;
    bus_b.instr_valid_i = 1'b0; bus_b.instr_ack_i = 1'b0; bus_b.class_i = '0; bus_b.flush_i = 1'b0;
  endtask

  task automatic step(input int dut, input logic v, input logic ack, input logic [NC-1:0] cls,
                      input logic fl);
    if (dut == 0) begin
      bus_a.instr_valid_i = v; bus_a.instr_ack_i = ack; bus_a.class_i = cls; bus_a.flush_i = fl;
    end else begin
      bus_b.instr_valid_i = v; bus_b.instr_ack_i = ack; bus_b.class_i = cls; bus_b.flush_i = fl;
    end
    @(posedge clk);
    #1;
    idle_all();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    rst_n = 1'b0;
    // Reset with random inputs on both instances
    for (int r = 0; r < 2; r++) begin
      bus_a.instr_valid_i = 1'($urandom); bus_a.instr_ack_i = 1'($urandom);
      bus_a.class_i = 4'($urandom); bus_a.flush_i = 1'($urandom);
      bus_b.instr_valid_i = 1'($urandom); bus_b.instr_ack_i = 1'($urandom);
      bus_b.class_i = 4'($urandom); bus_b.flush_i = 1'($urandom);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        exp_zero("reset", d, 0);
        for (int c = 0; c < NC; c++) exp_v("reset_perf", d, 0, K_PERF, c, 64'd0);
      end
    end
    checks++;
    if ((bus_a.hist_o !== '0) || (bus_a.cnt_o !== '0) || (bus_a.full_o !== 1'b0)) begin
      failures++;
      $display("FAIL reset_direct_a: hist=0x%0h cnt=0x%0h full=%0b",
               bus_a.hist_o, bus_a.cnt_o, bus_a.full_o);
    end
    checks++;
    if ((bus_b.hist_o !== '0) || (bus_b.cnt_o !== '0) || (bus_b.perf_cnt_o !== '0)) begin
      failures++;
      $display("FAIL reset_direct_b: hist=0x%0h cnt=0x%0h perf=0x%0h",
               bus_b.hist_o, bus_b.cnt_o, bus_b.perf_cnt_o);
    end
    idle_all();
    rst_n = 1'b1;
    step(0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Instance A: basic handshakes, idle and half-handshake cycles
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1, 4'b0001, 1'b0);
    exp_v("three_hs_hist0", 0, 1, K_HIST, 0, 64'h3800);
    exp_v("three_hs_cnt0", 0, 1, K_CNT, 0, 64'd3);
    step(0, 1'b1, 1'b0, 4'b0100, 1'b0);
    exp_v("valid_only_hist0", 0, 1, K_HIST, 0, 64'h3800);
    exp_v("valid_only_hist2", 0, 1, K_HIST, 2, 64'h0);
    step(0, 1'b0, 1'b1, 4'b1000, 1'b0);
    exp_v("ack_only_hist0", 0, 1, K_HIST, 0, 64'h3800);
    exp_v("ack_only_hist3", 0, 1, K_HIST, 3, 64'h0);
    step(0, 1'b1, 1'b1, 4'b0010, 1'b0);
    exp_v("mixed_hist0", 0, 1, K_HIST, 0, 64'h1C00);
    exp_v("mixed_hist1", 0, 1, K_HIST, 1, 64'h2000);
    exp_v("mixed_cnt0", 0, 1, K_CNT, 0, 64'd3);
    exp_v("mixed_cnt1", 0, 1, K_CNT, 1, 64'd1);
    exp_v("mixed_full", 0, 1, K_FULL, 0, 64'd0);
    exp_v("mixed_perf0", 0, 0, K_PERF, 0, pf(3));
    exp_v("mixed_perf1", 0, 0, K_PERF, 1, pf(1));
    step(0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Flush colliding with a handshake
    step(0, 1'b1, 1'b1, 4'b0001, 1'b1);
    exp_zero("flush", 0, 1);
    exp_v("flush_perf0", 0, 0, K_PERF, 0, pf(3));
    exp_v("flush_perf1", 0, 0, K_PERF, 1, pf(1));

    // Wrap: 16 of class 0 then 14 of class 1
    for (int i = 1; i <= 16; i++) begin
      step(0, 1'b1, 1'b1, 4'b0001, 1'b0);
      if (i == 13) exp_v("wrap_full_13", 0, 1, K_FULL, 0, 64'd0);
      if (i == 14) exp_v("wrap_full_14", 0, 1, K_FULL, 0, 64'd1);
    end
    exp_v("wrap_hist0_16", 0, 1, K_HIST, 0, 64'h3FFF);
    exp_v("wrap_cnt0_16", 0, 1, K_CNT, 0, 64'd14);
    for (int i = 1; i <= 14; i++) begin
      step(0, 1'b1, 1'b1, 4'b0010, 1'b0);
      if (i == 7) begin
        exp_v("wrap_mid_hist0", 0, 1, K_HIST, 0, 64'h007F);
        exp_v("wrap_mid_hist1", 0, 1, K_HIST, 1, 64'h3F80);
        exp_v("wrap_mid_cnt0", 0, 1, K_CNT, 0, 64'd7);
        exp_v("wrap_mid_cnt1", 0, 1, K_CNT, 1, 64'd7);
      end
    end
    exp_v("wrap_end_hist0", 0, 1, K_HIST, 0, 64'h0);
    exp_v("wrap_end_hist1", 0, 1, K_HIST, 1, 64'h3FFF);
    exp_v("wrap_end_cnt0", 0, 1, K_CNT, 0, 64'd0);
    exp_v("wrap_end_cnt1", 0, 1, K_CNT, 1, 64'd14);
    exp_v("wrap_end_full", 0, 1, K_FULL, 0, 64'd1);
    exp_v("wrap_end_perf0", 0, 0, K_PERF, 0, pf(19));
    exp_v("wrap_end_perf1", 0, 0, K_PERF, 1, pf(15));
    step(0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Reset asserted mid-operation, with a handshake on the same edge
    rst_n = 1'b0;
    step(0, 1'b1, 1'b1, 4'b0001, 1'b0);
    exp_zero("mid_reset", 0, 0);
    for (int c = 0; c < NC; c++) exp_v("mid_reset_perf", 0, 0, K_PERF, c, 64'd0);
    rst_n = 1'b1;
    step(0, 1'b1, 1'b1, 4'b0100, 1'b0);
    exp_v("post_reset_hist2", 0, 1, K_HIST, 2, 64'h2000);
    exp_v("post_reset_cnt2", 0, 1, K_CNT, 2, 64'd1);
    exp_v("post_reset_full", 0, 1, K_FULL, 0, 64'd0);
    exp_v("post_reset_perf2", 0, 0, K_PERF, 2, pf(1));

    // Instance B: free-running, zero output delay
    step(1, 1'b1, 1'b1, 4'b0001, 1'b0);
    exp_v("fr_hist0_1", 1, 0, K_HIST, 0, 64'h2000);
    step(1, 1'b0, 1'b0, 4'b0000, 1'b0);
    exp_v("fr_hist0_2", 1, 0, K_HIST, 0, 64'h1000);
    step(1, 1'b1, 1'b1, 4'b0001, 1'b0);
    exp_v("fr_hist0_3", 1, 0, K_HIST, 0, 64'h2800);
    step(1, 1'b0, 1'b0, 4'b0000, 1'b0);
    exp_v("fr_hist0_4", 1, 0, K_HIST, 0, 64'h1400);
    exp_v("fr_cnt0_4", 1, 0, K_CNT, 0, 64'd2);
    exp_v("fr_full_4", 1, 0, K_FULL, 0, 64'd0);
    for (int i = 1; i <= 11; i++) begin
      step(1, 1'b0, 1'b0, 4'b0000, 1'b0);
      if (i == 10) begin
        exp_v("fr_age_hist0_10", 1, 0, K_HIST, 0, 64'h0005);
        exp_v("fr_age_cnt0_10", 1, 0, K_CNT, 0, 64'd2);
      end
    end
    exp_v("fr_age_hist0_11", 1, 0, K_HIST, 0, 64'h0002);
    exp_v("fr_age_cnt0_11", 1, 0, K_CNT, 0, 64'd1);

    // Perf saturation with 4-bit counters
    for (int i = 1; i <= 20; i++) begin
      step(1, 1'b1, 1'b1, 4'b0100, 1'b0);
      if (i == 14) exp_v("sat_perf2_14", 1, 0, K_PERF, 2, pf(14));
      if (i == 15) exp_v("sat_perf2_15", 1, 0, K_PERF, 2, pf(15));
    end
    exp_v("sat_perf2_20", 1, 0, K_PERF, 2, pf(15));
    exp_v("sat_perf0_20", 1, 0, K_PERF, 0, pf(2));
    exp_v("sat_hist2_20", 1, 0, K_HIST, 2, 64'h3FFF);
    exp_v("sat_cnt2_20", 1, 0, K_CNT, 2, 64'd14);
    exp_v("sat_hist0_20", 1, 0, K_HIST, 0, 64'h0);
    exp_v("sat_cnt0_20", 1, 0, K_CNT, 0, 64'd0);
    exp_v("sat_full_20", 1, 0, K_FULL, 0, 64'd1);

    repeat (3) step(0, 1'b0, 1'b0, 4'b0000, 1'b0);
    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL %s dut=%0d: never compared (due cycle %0d, now %0d)",
               sb[i].name, sb[i].dut, sb[i].due, cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
